piso_tx: RTL and testbench

PISO_TX -- requirements
Module: piso_tx

---
 rtl/piso_pkg.sv | 15 +
 rtl/piso_tx.sv | 59 +++++
 tb/tb_piso_tx.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared definitions for the parallel-in serial-out transmitter:
// FSM state encoding and the bit-counter width helper.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must hold 0..w-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: captures a WIDTH-bit word on a
// valid/ready handshake and emits it LSB first, one bit per cycle.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             shift_en,
  output logic             busy,
  output logic             done
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] sreg;
  logic             last;
  logic             accept;

  // Output decode uses only state and counter, so ready never depends on valid.
  assign last       = (state == SHIFT) && (cnt == LAST);
  assign load_ready = (state == IDLE) || last;
  assign accept     = load_valid && load_ready;

  assign busy     = (state == SHIFT);
  assign shift_en = (state == SHIFT);
  assign done     = last;
  assign sout     = (state == SHIFT) && sreg[0];

  always_ff @(posedge clk) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else if (accept) begin
      state <= SHIFT;
      cnt   <= '0;
      sreg  <= data_in;
    end else if (state == SHIFT) begin
      // Zero fill keeps the register clear once the word has drained.
      sreg <= {1'b0, sreg[WIDTH-1:1]};
      if (last) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx at WIDTH = 3, 2, 16 and 8, with a serial-in
// register model on the WIDTH=3 instance for loopback.
module tb_piso_tx;

  logic        clk;
  logic [15:0] din;
  logic        rst [4];
  logic        lv  [4];
  logic        lr  [4];
  logic        so  [4];
  logic        se  [4];
  logic        bz  [4];
  logic        dn  [4];
  logic [15:0] cnt_obs [4];
  logic [2:0]  sipo;

  int tests = 0;
  int fails = 0;

  piso_tx #(.WIDTH(3)) u_w3 (
    .clk(clk), .Reset(rst[0]), .data_in(din[2:0]), .load_valid(lv[0]),
    .load_ready(lr[0]), .sout(so[0]), .shift_en(se[0]), .busy(bz[0]), .done(dn[0])
  );
  piso_tx #(.WIDTH(2)) u_w2 (
    .clk(clk), .Reset(rst[1]), .data_in(din[1:0]), .load_valid(lv[1]),
    .load_ready(lr[1]), .sout(so[1]), .shift_en(se[1]), .busy(bz[1]), .done(dn[1])
  );
  piso_tx #(.WIDTH(16)) u_w16 (
    .clk(clk), .Reset(rst[2]), .data_in(din[15:0]), .load_valid(lv[2]),
    .load_ready(lr[2]), .sout(so[2]), .shift_en(se[2]), .busy(bz[2]), .done(dn[2])
  );
  piso_tx #(.WIDTH(8)) u_w8 (
    .clk(clk), .Reset(rst[3]), .data_in(din[7:0]), .load_valid(lv[3]),
    .load_ready(lr[3]), .sout(so[3]), .shift_en(se[3]), .busy(bz[3]), .done(dn[3])
  );

  assign cnt_obs[0] = 16'(u_w3.cnt);
  assign cnt_obs[1] = 16'(u_w2.cnt);
  assign cnt_obs[2] = 16'(u_w16.cnt);
  assign cnt_obs[3] = 16'(u_w8.cnt);

  // Downstream serial-in register: LSB arrives first, so shift toward bit 0.
  always_ff @(posedge clk) begin
    if (rst[0])     sipo <= '0;
    else if (se[0]) sipo <= {so[0], sipo[2:1]};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin rst[k] = 1'b1; lv[k] = 1'b0; end
    din = '0;
    @(posedge clk); @(posedge clk); #1;
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (so[k] !== 1'b0 || se[k] !== 1'b0 || bz[k] !== 1'b0 || dn[k] !== 1'b0 || lr[k] !== 1'b1) begin
        fails++;
        $display("FAIL reset[%0d]: sout=%b se=%b busy=%b done=%b ready=%b, want 0 0 0 0 1",
                 k, so[k], se[k], bz[k], dn[k], lr[k]);
      end
    end
  endtask

  task automatic test_single(input int sel, input int w, input logic [15:0] word, input string name);
    tests++;
    if (lr[sel] !== 1'b1) begin fails++; $display("FAIL %s ready_idle: got %b want 1", name, lr[sel]); end
    din = word; lv[sel] = 1'b1;
    @(posedge clk); #1;
    lv[sel] = 1'b0;
    for (int i = 0; i < w; i++) begin
      tests++;
      if (se[sel] !== 1'b1 || bz[sel] !== 1'b1 || so[sel] !== word[i] ||
          dn[sel] !== 1'(i == w-1) || lr[sel] !== 1'(i == w-1)) begin
        fails++;
        $display("FAIL %s bit%0d: se=%b busy=%b sout=%b done=%b ready=%b, want 1 1 %b %b %b",
                 name, i, se[sel], bz[sel], so[sel], dn[sel], lr[sel], word[i], i == w-1, i == w-1);
      end
      tests++;
      if (cnt_obs[sel] !== 16'(i)) begin
        fails++; $display("FAIL %s cnt%0d: got %0d want %0d", name, i, cnt_obs[sel], i);
      end
      @(posedge clk); #1;
    end
    tests++;
    if (se[sel] !== 1'b0 || bz[sel] !== 1'b0 || lr[sel] !== 1'b1 || so[sel] !== 1'b0 || dn[sel] !== 1'b0) begin
      fails++;
      $display("FAIL %s idle_after: se=%b busy=%b ready=%b sout=%b done=%b, want 0 0 1 0 0",
               name, se[sel], bz[sel], lr[sel], so[sel], dn[sel]);
    end
  endtask

  task automatic test_back_to_back(input int sel, input int w, input logic [15:0] a,
                                   input logic [15:0] b, input string name);
    int dones;
    logic exp_bit;
    dones = 0;
    din = a; lv[sel] = 1'b1;
    @(posedge clk); #1;
    lv[sel] = 1'b0;
    for (int i = 0; i < 2*w; i++) begin
      exp_bit = (i < w) ? a[i] : b[i-w];
      if (dn[sel] === 1'b1) dones++;
      tests++;
      if (se[sel] !== 1'b1 || so[sel] !== exp_bit || dn[sel] !== 1'((i % w) == w-1) ||
          lr[sel] !== 1'((i % w) == w-1)) begin
        fails++;
        $display("FAIL %s cyc%0d: se=%b sout=%b done=%b ready=%b, want 1 %b %b %b",
                 name, i, se[sel], so[sel], dn[sel], lr[sel], exp_bit, (i % w) == w-1, (i % w) == w-1);
      end
      tests++;
      if (cnt_obs[sel] !== 16'(i % w)) begin
        fails++; $display("FAIL %s cnt%0d: got %0d want %0d", name, i, cnt_obs[sel], i % w);
      end
      if (i == w-1) begin din = b; lv[sel] = 1'b1; end
      else lv[sel] = 1'b0;
      @(posedge clk); #1;
    end
    lv[sel] = 1'b0;
    tests++;
    if (dones != 2) begin fails++; $display("FAIL %s done_count: got %0d want 2", name, dones); end
    tests++;
    if (se[sel] !== 1'b0 || bz[sel] !== 1'b0 || lr[sel] !== 1'b1) begin
      fails++;
      $display("FAIL %s idle_after: se=%b busy=%b ready=%b, want 0 0 1", name, se[sel], bz[sel], lr[sel]);
    end
  endtask

  task automatic test_loopback();
    for (int v = 0; v < 8; v++) begin
      test_single(0, 3, 16'(v), "loop");
      tests++;
      if (sipo !== 3'(v)) begin fails++; $display("FAIL loopback word%0d: got %b want %b", v, sipo, 3'(v)); end
    end
  endtask

  task automatic test_ignored_load();
    logic [2:0] seen;
    int extra;
    seen = '0; extra = 0;
    din = 16'h0000; lv[0] = 1'b1;
    @(posedge clk); #1;
    lv[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      seen[i] = so[0];
      tests++;
      if (se[0] !== 1'b1 || so[0] !== 1'b0) begin
        fails++; $display("FAIL ignore bit%0d: se=%b sout=%b want 1 0", i, se[0], so[0]);
      end
      if (i == 1) begin din = 16'h0007; lv[0] = 1'b1; end
      else lv[0] = 1'b0;
      @(posedge clk); #1;
    end
    lv[0] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (se[0] !== 1'b0) extra++;
      @(posedge clk); #1;
    end
    tests++;
    if (seen !== 3'b000 || extra != 0) begin
      fails++; $display("FAIL ignore word: bits=%b extra_cycles=%0d want 000 0", seen, extra);
    end
  endtask

  task automatic test_midword_reset();
    int bad;
    bad = 0;
    din = 16'h00A5; lv[3] = 1'b1;
    @(posedge clk); #1;
    lv[3] = 1'b0;
    tests++;
    if (se[3] !== 1'b1 || so[3] !== 1'b1 || dn[3] !== 1'b0) begin
      fails++; $display("FAIL rstmid bit0: se=%b sout=%b done=%b want 1 1 0", se[3], so[3], dn[3]);
    end
    @(posedge clk); #1;
    tests++;
    if (se[3] !== 1'b1 || so[3] !== 1'b0 || dn[3] !== 1'b0) begin
      fails++; $display("FAIL rstmid bit1: se=%b sout=%b done=%b want 1 0 0", se[3], so[3], dn[3]);
    end
    rst[3] = 1'b1;
    @(posedge clk); #1;
    rst[3] = 1'b0;
    tests++;
    if (se[3] !== 1'b0 || bz[3] !== 1'b0 || lr[3] !== 1'b1 || dn[3] !== 1'b0 || so[3] !== 1'b0) begin
      fails++;
      $display("FAIL rstmid after: se=%b busy=%b ready=%b done=%b sout=%b want 0 0 1 0 0",
               se[3], bz[3], lr[3], dn[3], so[3]);
    end
    for (int i = 0; i < 10; i++) begin
      if (se[3] !== 1'b0 || dn[3] !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    tests++;
    if (bad != 0) begin fails++; $display("FAIL rstmid tail: active cycles=%0d want 0", bad); end
    // Reset and accept on the same edge: reset must win.
    din = 16'h00FF; lv[3] = 1'b1; rst[3] = 1'b1;
    @(posedge clk); #1;
    lv[3] = 1'b0; rst[3] = 1'b0;
    tests++;
    if (bz[3] !== 1'b0 || se[3] !== 1'b0 || lr[3] !== 1'b1) begin
      fails++; $display("FAIL rst_prio: busy=%b se=%b ready=%b want 0 0 1", bz[3], se[3], lr[3]);
    end
    @(posedge clk); #1;
    tests++;
    if (se[3] !== 1'b0) begin fails++; $display("FAIL rst_prio later: se=%b want 0", se[3]); end
  endtask

  initial begin
    test_reset();
    test_single(0, 3, 16'b110, "w3_single");
    test_back_to_back(0, 3, 16'b101, 16'b010, "w3_b2b");
    test_loopback();
    test_ignored_load();
    test_midword_reset();
    test_single(1, 2, 16'b10, "w2_single");
    test_back_to_back(1, 2, 16'b01, 16'b10, "w2_b2b");
    test_single(2, 16, 16'hBEEF, "w16_single");
    test_back_to_back(2, 16, 16'hBEEF, 16'h1234, "w16_b2b");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
